// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message arbiter sharing one UART TX byte port
module uart_tx_arbiter #(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [2:0]        grant_id,
  output logic              busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state;
  logic [GW-1:0]   gnt;
  logic [CW-1:0]   count;
  logic            buf_full;
  logic [7:0]      buf_data;

  logic [GW-1:0]   winner;
  logic [GW-1:0]   cand;
  logic            any_valid;
  logic            room;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic            accept;
  logic            burst_done;

  // Rotating-priority scan: first valid requester after the last grant, wrapping
  always_comb begin
    winner    = gnt;
    any_valid = 1'b0;
    cand      = gnt;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(gnt) + k) % NREQ);
      if (!any_valid && req_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  assign sel_valid  = req_valid[gnt];
  assign sel_last   = req_last[gnt];
  assign sel_data   = req_data[{gnt, 3'b000} +: 8];
  // The buffer can take a byte when empty or when it drains in the same cycle
  assign room       = !buf_full || tx_ready;
  assign accept     = (state == LOCK) && sel_valid && room;
  assign burst_done = (MAX_BURST != 0) && ((int'(count) + 1) == MAX_BURST);

  // Only the locked requester sees ready, and only when the buffer has room
  always_comb begin
    req_ready = '0;
    if (state == LOCK) begin
      req_ready[gnt] = room;
    end
  end

  // Arbitration FSM plus the one-entry output buffer
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= GW'(NREQ - 1);
      count    <= '0;
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      if (accept) begin
        buf_full <= 1'b1;
        buf_data <= sel_data;
      end else if (buf_full && tx_ready) begin
        buf_full <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (enable && any_valid) begin
            gnt   <= winner;
            count <= '0;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (accept) begin
            count <= count + CW'(1);
            if (sel_last || burst_done) begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign tx_valid = buf_full;
  assign tx_data  = buf_data;
  assign grant_id = 3'(gnt);
  assign busy     = (state == LOCK) || buf_full;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int MB = 4;

  logic            CLK = 1'b0;
  logic            reset;
  logic            enable;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic [2:0]      grant_id;
  logic            busy;

  uart_tx_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .enable    (enable),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  logic [8:0]  q [N][$];
  logic [7:0]  obs[$];
  logic [11:0] acc_log[$];
  logic [11:0] exp_q[$];
  int          exp_ptr;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = q[i][0][7:0];
        req_last[i]        = q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic set_ready(input logic b);
    tx_ready = b;
    #1;
  endtask

  task automatic tick();
    logic [N-1:0] took;
    took = '0;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        took[i] = 1'b1;
        acc_log.push_back({3'(i), req_last[i], req_data[8*i +: 8]});
      end
    end
    if (tx_valid && tx_ready) obs.push_back(tx_data);
    @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i < N; i++) if (took[i]) void'(q[i].pop_front());
    drive();
    #1;
  endtask

  // Message-level reference: grants rotate over requesters with pending bytes,
  // each grant runs to a last byte or MB bytes, whichever comes first.
  task automatic model();
    logic [8:0] m [N][$];
    int p, c, n;
    bit found, stop;
    logic [8:0] e;
    for (int i = 0; i < N; i++) m[i] = q[i];
    exp_q.delete();
    p = exp_ptr;
    for (int g = 0; g < 1000; g++) begin
      found = 1'b0;
      c = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && m[(p + k) % N].size() > 0) begin
          found = 1'b1;
          c = (p + k) % N;
        end
      end
      if (!found) break;
      n = 0;
      stop = 1'b0;
      while (!stop) begin
        e = m[c].pop_front();
        exp_q.push_back({3'(c), e});
        n++;
        stop = e[8] || (MB != 0 && n == MB) || m[c].size() == 0;
      end
      p = c;
    end
    exp_ptr = p;
  endtask

  task automatic run_phase(input string name, input int pct, input bit rnd_en);
    bit timed_out;
    model();
    obs.delete();
    acc_log.delete();
    drive();
    #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (all_empty() && obs.size() >= exp_q.size()) break;
      tx_ready = ($urandom_range(0, 99) < pct);
      enable   = rnd_en ? ($urandom_range(0, 99) < 70) : 1'b1;
      #1;
      tick();
    end
    timed_out = !(all_empty() && obs.size() >= exp_q.size());
    chk({name, "_timeout"}, 32'(timed_out), 32'd0);
    chk({name, "_acc_count"}, acc_log.size(), exp_q.size());
    chk({name, "_tx_count"}, obs.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < acc_log.size()) chk($sformatf("%s_acc_%0d", name, k), 32'(acc_log[k]), 32'(exp_q[k]));
      if (k < obs.size())     chk($sformatf("%s_tx_%0d", name, k), 32'(obs[k]), 32'(exp_q[k][7:0]));
    end
    chk({name, "_gid_end"}, 32'(grant_id), exp_ptr);
    enable   = 1'b1;
    tx_ready = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cexp [4];
    int nm, len;
    reset = 1'b1; enable = 1'b0; tx_ready = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    exp_ptr = N - 1;
    #1 reset = 1'b0;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_grant_id", 32'(grant_id), N - 1);
    chk("rst_busy", 32'(busy), 0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1; enable = 1'b1; tx_ready = 1'b1;

    // single requester, latency and consecutive bytes
    q[0].push_back(9'h041); q[0].push_back(9'h042); q[0].push_back(9'h143);
    drive(); #1;
    chk("s_c0_ready", 32'(req_ready), 0);
    chk("s_c0_busy", 32'(busy), 0);
    tick();
    chk("s_c1_ready", 32'(req_ready), 32'b001);
    chk("s_c1_gid", 32'(grant_id), 0);
    chk("s_c1_txv", 32'(tx_valid), 0);
    tick();
    chk("s_c2_txv", 32'(tx_valid), 1);
    chk("s_c2_data", 32'(tx_data), 32'h41);
    tick();
    chk("s_c3_data", 32'(tx_data), 32'h42);
    tick();
    chk("s_c4_data", 32'(tx_data), 32'h43);
    chk("s_c4_busy", 32'(busy), 1);
    tick();
    chk("s_c5_txv", 32'(tx_valid), 0);
    chk("s_c5_busy", 32'(busy), 0);

    // backpressure on the first byte
    q[1].push_back(9'h055); q[1].push_back(9'h1AA);
    drive(); #1;
    tick();
    chk("bp_ready", 32'(req_ready), 32'b010);
    chk("bp_gid", 32'(grant_id), 1);
    tick();
    set_ready(1'b0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold_txv_%0d", k), 32'(tx_valid), 1);
      chk($sformatf("bp_hold_data_%0d", k), 32'(tx_data), 32'h55);
      chk($sformatf("bp_hold_ready_%0d", k), 32'(req_ready), 0);
      tick();
    end
    set_ready(1'b1);
    chk("bp_resume_ready", 32'(req_ready), 32'b010);
    tick();
    chk("bp_second_txv", 32'(tx_valid), 1);
    chk("bp_second_data", 32'(tx_data), 32'hAA);
    tick();
    chk("bp_done_txv", 32'(tx_valid), 0);
    chk("bp_done_busy", 32'(busy), 0);

    // reset in the middle of a message with a full buffer
    q[1].push_back(9'h061); q[1].push_back(9'h062); q[1].push_back(9'h163);
    drive(); #1;
    tick();
    tick();
    set_ready(1'b0);
    chk("rm_pre_busy", 32'(busy), 1);
    chk("rm_pre_txv", 32'(tx_valid), 1);
    reset = 1'b0;
    #1;
    chk("rm_txv", 32'(tx_valid), 0);
    chk("rm_ready", 32'(req_ready), 0);
    chk("rm_gid", 32'(grant_id), N - 1);
    chk("rm_busy", 32'(busy), 0);
    q[1].delete();
    drive();
    tick();
    obs.delete();
    acc_log.delete();
    reset = 1'b1;
    tx_ready = 1'b1;

    // contention between requesters 0 and 2 straight after reset
    q[0].push_back(9'h011); q[0].push_back(9'h112);
    q[2].push_back(9'h031); q[2].push_back(9'h132);
    drive(); #1;
    tick();
    chk("ct_gid0", 32'(grant_id), 0);
    chk("ct_ready0", 32'(req_ready), 32'b001);
    tick();
    tick();
    chk("ct_bubble_ready", 32'(req_ready), 0);
    chk("ct_bubble_gid", 32'(grant_id), 0);
    tick();
    chk("ct_gid2", 32'(grant_id), 2);
    chk("ct_ready2", 32'(req_ready), 32'b100);
    tick();
    tick();
    tick();
    cexp[0] = 8'h11; cexp[1] = 8'h12; cexp[2] = 8'h31; cexp[3] = 8'h32;
    chk("ct_count", obs.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < obs.size()) chk($sformatf("ct_tx_%0d", k), 32'(obs[k]), 32'(cexp[k]));
    end
    exp_ptr = 2;

    // round-robin rotation with one-byte messages
    for (int i = 0; i < N; i++) begin
      for (int m = 0; m < ((i == 0) ? 3 : 2); m++) q[i].push_back({1'b1, 8'(8'hA0 + 16 * i + m)});
    end
    run_phase("rot", 100, 1'b0);

    // burst cap: requester 1 streams 10 bytes while requester 0 waits
    for (int b = 0; b < 10; b++) q[1].push_back({(b == 9), 8'(8'hC0 + b)});
    q[0].push_back(9'h1EE);
    run_phase("burst", 100, 1'b0);

    // randomized traffic, backpressure and enable
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          nm = $urandom_range(1, 3);
          for (int m = 0; m < nm; m++) begin
            len = $urandom_range(1, 7);
            for (int b = 0; b < len; b++) q[i].push_back({(b == len - 1), 8'($urandom)});
          end
        end
      end
      run_phase($sformatf("rnd%0d", r), $urandom_range(40, 100), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
